hazard_forward_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage core (F/D/E/M/W).

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_stage_rec.sv | 36 +++
 rtl/hazard_forward_unit.sv | 87 ++++++++
 tb/tb_hazard_forward_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE   = 2'd3;
    localparam int         FWD_A_EARLY = 2;
    localparam int         FWD_A_LATE  = 3;
    localparam int         FWD_B_EARLY = 0;
    localparam int         FWD_B_LATE  = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_rec_t;

    // Producer holds a finished result for src this cycle.
    function automatic logic fwd_ready(input stage_rec_t p, input logic [4:0] src);
        return p.valid && (p.dst == src) && (src != 5'd0) && (p.tnew == 2'd0);
    endfunction

    // Producer still owes a result for src later than the consumer needs it.
    function automatic logic pending(input stage_rec_t p, input logic [4:0] src,
                                     input logic [1:0] tuse);
        return p.valid && (p.dst == src) && (p.tnew > tuse);
    endfunction

    // Two-producer select pair {late, early}; the younger producer wins.
    function automatic logic [1:0] fwd_pair(input stage_rec_t early, input stage_rec_t late,
                                            input logic [4:0] src);
        logic e;
        e = fwd_ready(early, src);
        return {(!e && fwd_ready(late, src)), e};
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One pipeline-stage shadow record; optionally ages Tnew by one (saturating at 0).
module hazard_stage_rec
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  stage_rec_t i_rec,
    input  logic       dec_tnew,
    output stage_rec_t o_rec
);

    stage_rec_t w_next;
    stage_rec_t r_rec;

    // Next record: copy with optional saturating Tnew decrement.
    always_comb begin
        w_next = i_rec;
        if (dec_tnew && (i_rec.tnew != 2'd0)) begin
            w_next.tnew = i_rec.tnew - 2'd1;
        end else begin
            w_next.tnew = i_rec.tnew;
        end
    end

    // Record register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rec <= '0;
        end else begin
            r_rec <= w_next;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/hazard_forward_unit.sv
// Stall and forward-select generation for the F/D/E/M/W core, tracking E/M/W
// producers with shadow records that advance in lockstep with the datapath.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int TNEW_W     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rsD,
    input  logic [REG_ADDR_W-1:0] rtD,
    input  logic [TNEW_W-1:0]     tuseRsD,
    input  logic [TNEW_W-1:0]     tuseRtD,
    input  logic                  regWriteD,
    input  logic [REG_ADDR_W-1:0] dstD,
    input  logic [TNEW_W-1:0]     tnewD,
    output logic                  stall,
    output logic [3:0]            fwdSelD,
    output logic [3:0]            fwdSelE,
    output logic [1:0]            fwdSelM
);

    stage_rec_t w_rec_e_in;
    stage_rec_t w_rec_w_in;
    stage_rec_t w_rec_e;
    stage_rec_t w_rec_m;
    stage_rec_t w_rec_w;
    logic       w_hit_rs;
    logic       w_hit_rt;
    logic [1:0] w_pair;
    logic       w_unused_w;

    // A stalled D instruction enters E as a bubble; $0 writers are never producers.
    always_comb begin
        w_rec_e_in = '0;
        if (!stall) begin
            w_rec_e_in.valid = regWriteD && (dstD != 5'd0);
            w_rec_e_in.dst   = dstD;
            w_rec_e_in.tnew  = tnewD;
            w_rec_e_in.rs    = rsD;
            w_rec_e_in.rt    = rtD;
        end else begin
            w_rec_e_in.valid = 1'b0;
        end
        w_rec_w_in      = w_rec_m;
        w_rec_w_in.tnew = 2'd0;
    end

    hazard_stage_rec u_rec_e (.clk(clk), .reset_n(reset_n), .i_rec(w_rec_e_in), .dec_tnew(1'b0), .o_rec(w_rec_e));
    hazard_stage_rec u_rec_m (.clk(clk), .reset_n(reset_n), .i_rec(w_rec_e),    .dec_tnew(1'b1), .o_rec(w_rec_m));
    hazard_stage_rec u_rec_w (.clk(clk), .reset_n(reset_n), .i_rec(w_rec_w_in), .dec_tnew(1'b0), .o_rec(w_rec_w));

    // W consumes nothing downstream, so its source fields are never inspected.
    assign w_unused_w = ^{w_rec_w.rs, w_rec_w.rt};

    // Stall when an E/M producer cannot deliver before the operand is used.
    always_comb begin
        w_hit_rs = (tuseRsD != TUSE_NONE) && (rsD != 5'd0) &&
                   (pending(w_rec_e, rsD, tuseRsD) || pending(w_rec_m, rsD, tuseRsD));
        w_hit_rt = (tuseRtD != TUSE_NONE) && (rtD != 5'd0) &&
                   (pending(w_rec_e, rtD, tuseRtD) || pending(w_rec_m, rtD, tuseRtD));
        stall    = w_hit_rs || w_hit_rt;
    end

    // Forward selects per consuming stage; the younger producer takes priority.
    always_comb begin
        fwdSelD = 4'd0;
        fwdSelE = 4'd0;
        fwdSelM = 2'd0;
        w_pair  = fwd_pair(w_rec_e, w_rec_m, rsD);
        fwdSelD[FWD_A_EARLY] = w_pair[0];
        fwdSelD[FWD_A_LATE]  = w_pair[1];
        w_pair  = fwd_pair(w_rec_e, w_rec_m, rtD);
        fwdSelD[FWD_B_EARLY] = w_pair[0];
        fwdSelD[FWD_B_LATE]  = w_pair[1];
        w_pair  = fwd_pair(w_rec_m, w_rec_w, w_rec_e.rs);
        fwdSelE[FWD_A_EARLY] = w_pair[0];
        fwdSelE[FWD_A_LATE]  = w_pair[1];
        w_pair  = fwd_pair(w_rec_m, w_rec_w, w_rec_e.rt);
        fwdSelE[FWD_B_EARLY] = w_pair[0];
        fwdSelE[FWD_B_LATE]  = w_pair[1];
        fwdSelM[1] = fwd_ready(w_rec_w, w_rec_m.rs);
        fwdSelM[0] = fwd_ready(w_rec_w, w_rec_m.rt);
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scenarios plus random traffic, checked against an age-indexed
// model of in-flight instructions.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rsD, rtD, dstD;
    logic [1:0] tuseRsD, tuseRtD, tnewD;
    logic       regWriteD;
    logic       stall;
    logic [3:0] fwdSelD, fwdSelE;
    logic [1:0] fwdSelM;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit v;
        int dst;
        int tn;
        int rs;
        int rt;
    } ins_t;

    // hist[age]: age 0 = E, 1 = M, 2 = W
    ins_t hist [3];

    hazard_forward_unit dut (
        .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD),
        .tuseRsD(tuseRsD), .tuseRtD(tuseRtD), .regWriteD(regWriteD),
        .dstD(dstD), .tnewD(tnewD), .stall(stall),
        .fwdSelD(fwdSelD), .fwdSelE(fwdSelE), .fwdSelM(fwdSelM)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Cycles left until the instruction of this age has its result.
    function automatic int tnow(input int age);
        if (age == 2) return 0;
        return (hist[age].tn > age) ? hist[age].tn - age : 0;
    endfunction

    function automatic bit live(input int age, input int r);
        return (r != 0) && hist[age].v && (hist[age].dst == r);
    endfunction

    function automatic bit ready(input int age, input int r);
        return live(age, r) && (tnow(age) == 0);
    endfunction

    function automatic bit src_stall(input int r, input int t);
        if (t == 3 || r == 0) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (live(a, r) && tnow(a) > t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return src_stall(int'(rsD), int'(tuseRsD)) || src_stall(int'(rtD), int'(tuseRtD));
    endfunction

    // Select pair {late, early} for consumer reg r with producers at ages ea, ea+1.
    function automatic logic [1:0] m_pair(input int ea, input int r);
        bit e;
        e = ready(ea, r);
        return {(!e && ready(ea + 1, r)), e};
    endfunction

    task automatic drive(input bit rn, input int rs, input int rt, input int tus, input int tut,
                         input bit rw, input int dst, input int tn);
        @(negedge clk);
        reset_n   = rn;
        rsD       = 5'(rs);
        rtD       = 5'(rt);
        tuseRsD   = 2'(tus);
        tuseRtD   = 2'(tut);
        regWriteD = rw;
        dstD      = 5'(dst);
        tnewD     = 2'(tn);
        #1;
    endtask

    task automatic checkm(input string tag);
        logic [1:0] a, b;
        check_eq({tag, ".stall"}, {7'd0, stall}, {7'd0, m_stall()});
        a = m_pair(0, int'(rsD));
        b = m_pair(0, int'(rtD));
        check_eq({tag, ".fwdD"}, {4'd0, fwdSelD}, {4'd0, a, b});
        a = m_pair(1, hist[0].rs);
        b = m_pair(1, hist[0].rt);
        check_eq({tag, ".fwdE"}, {4'd0, fwdSelE}, {4'd0, a, b});
        check_eq({tag, ".fwdM"}, {6'd0, fwdSelM}, {6'd0, ready(2, hist[1].rs), ready(2, hist[1].rt)});
    endtask

    task automatic tick();
        bit   s;
        ins_t n;
        s = m_stall();
        n = '{v: 1'b0, dst: 0, tn: 0, rs: 0, rt: 0};
        if (!s) n = '{v: regWriteD && (dstD != 5'd0), dst: int'(dstD), tn: int'(tnewD),
                      rs: int'(rsD), rt: int'(rtD)};
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, dst: 0, tn: 0, rs: 0, rt: 0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = n;
        end
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) begin
            drive(1'b1, 0, 0, 3, 3, 1'b0, 0, 0);
            checkm("nop");
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{v: 1'b0, dst: 0, tn: 0, rs: 0, rt: 0};

        // T1 reset with live D inputs
        drive(1'b0, 8, 9, 0, 0, 1'b1, 8, 2);
        tick();
        drive(1'b0, 8, 9, 0, 0, 1'b1, 8, 2);
        checkm("t1");
        tick();
        drive(1'b1, 8, 9, 0, 0, 1'b1, 8, 2);
        checkm("t1_post");
        check_eq("t1.stall0", {7'd0, stall}, 8'd0);
        check_eq("t1.sel0", {fwdSelD, fwdSelE}, 8'd0);
        tick();
        nops(3);

        // T2 load-use
        drive(1'b1, 0, 0, 3, 3, 1'b1, 8, 2); checkm("t2_lw"); tick();
        drive(1'b1, 8, 9, 1, 1, 1'b1, 10, 1); checkm("t2_c1");
        check_eq("t2.c1_stall", {7'd0, stall}, 8'd1); tick();
        drive(1'b1, 8, 9, 1, 1, 1'b1, 10, 1); checkm("t2_c2");
        check_eq("t2.c2_stall", {7'd0, stall}, 8'd0); tick();
        drive(1'b1, 0, 0, 3, 3, 1'b0, 0, 0); checkm("t2_c3");
        check_eq("t2.c3_fwdE", {4'd0, fwdSelE}, 8'b1000); tick();
        nops(3);

        // T3 ALU chain
        drive(1'b1, 1, 2, 1, 1, 1'b1, 3, 1); checkm("t3_p"); tick();
        drive(1'b1, 3, 3, 1, 1, 1'b1, 6, 1); checkm("t3_c");
        check_eq("t3.stall", {7'd0, stall}, 8'd0); tick();
        drive(1'b1, 0, 0, 3, 3, 1'b0, 0, 0); checkm("t3_e");
        check_eq("t3.fwdE", {4'd0, fwdSelE}, 8'b0101); tick();
        nops(3);

        // T4 younger producer wins
        drive(1'b1, 1, 2, 1, 1, 1'b1, 5, 1); checkm("t4_p1"); tick();
        drive(1'b1, 1, 2, 1, 1, 1'b1, 5, 1); checkm("t4_p2"); tick();
        drive(1'b1, 5, 5, 1, 1, 1'b1, 7, 1); checkm("t4_c"); tick();
        drive(1'b1, 0, 0, 3, 3, 1'b0, 0, 0); checkm("t4_e");
        check_eq("t4.fwdE", {4'd0, fwdSelE}, 8'b0101); tick();
        nops(3);

        // T5 branch in D
        drive(1'b1, 1, 2, 1, 1, 1'b1, 4, 1); checkm("t5_p"); tick();
        drive(1'b1, 4, 0, 0, 3, 1'b0, 0, 0); checkm("t5_c1");
        check_eq("t5.c1_stall", {7'd0, stall}, 8'd1); tick();
        drive(1'b1, 4, 0, 0, 3, 1'b0, 0, 0); checkm("t5_c2");
        check_eq("t5.c2_fwdD", {4'd0, fwdSelD}, 8'b1000); tick();
        nops(3);

        // T6 $0 producer, then reset while stalled
        drive(1'b1, 1, 2, 1, 1, 1'b1, 0, 2); checkm("t6_z"); tick();
        drive(1'b1, 0, 0, 0, 0, 1'b1, 9, 1); checkm("t6_zc");
        check_eq("t6.z_out", {stall, fwdSelD, 3'd0}, 8'd0); tick();
        nops(3);
        drive(1'b1, 0, 0, 3, 3, 1'b1, 8, 2); checkm("t6_lw"); tick();
        drive(1'b1, 8, 0, 0, 3, 1'b0, 0, 0); checkm("t6_s");
        check_eq("t6.stall", {7'd0, stall}, 8'd1); tick();
        drive(1'b0, 8, 0, 0, 3, 1'b0, 0, 0); checkm("t6_rst"); tick();
        drive(1'b1, 8, 0, 0, 3, 1'b0, 0, 0); checkm("t6_post");
        check_eq("t6.post_stall", {7'd0, stall}, 8'd0);
        check_eq("t6.post_sel", {fwdSelD, fwdSelE}, 8'd0);
        tick();

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7), $urandom_range(0, 2));
            checkm("rnd");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
